hilo_ctrl: RTL and testbench

//  EX-stage HI/LO unit of the five-stage MIPS core; the stage directly upstream of the divider.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/hilo_ctrl.sv | 108 ++++++++++
 tb/tb_hilo_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared HI/LO op encoding, controller states and divider op codes.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } hilo_state_t;

    localparam logic [1:0] DIV_IDLE     = 2'b00;
    localparam logic [1:0] DIV_UNSIGNED = 2'b01;
    localparam logic [1:0] DIV_SIGNED   = 2'b10;

endpackage

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO unit: MULT/MULTU/MTHI/MTLO, DIV/DIVU issue and stall control.
// Define HILO_BYPASS_EN to forward the committed HI/LO value onto hi/lo in the same cycle.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] HILO_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    input  hilo_op_t             op,
    input  logic [WIDTH-1:0]     rs_data,
    input  logic [WIDTH-1:0]     rt_data,
    input  logic                 flush,
    output logic                 stall,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo,
    output logic [1:0]           div_op,
    output logic [WIDTH-1:0]     div_dividend,
    output logic [WIDTH-1:0]     div_divisor,
    input  logic [2*WIDTH-1:0]   div_result,
    input  logic                 div_done
);

    hilo_state_t        state;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic               div_req;
    logic               div_commit;
    logic               accept;
    logic               mul_signed;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;

    // One multiplier serves both MULT and MULTU: only the operand extension differs.
    assign mul_signed = (op == OP_MULT);
    assign mul_a      = {{WIDTH{mul_signed & rs_data[WIDTH-1]}}, rs_data};
    assign mul_b      = {{WIDTH{mul_signed & rt_data[WIDTH-1]}}, rt_data};
    assign product    = mul_a * mul_b;

    assign div_dividend = rs_data;
    assign div_divisor  = rt_data;

    always_comb begin
        div_req    = rst_n & op_valid & ~flush
                   & ((op == OP_DIV) | (op == OP_DIVU)) & (rt_data != '0);
        stall      = 1'b0;
        div_op     = DIV_IDLE;
        div_commit = 1'b0;
        case (state)
            IDLE: begin
                stall = div_req;
                if (div_req && div_done)
                    div_op = (op == OP_DIV) ? DIV_SIGNED : DIV_UNSIGNED;
            end
            WAIT: begin
                stall      = rst_n & ~flush & ~div_done;
                div_commit = rst_n & ~flush & div_done;
            end
            DRAIN: stall = div_req;
            default: stall = 1'b0;
        endcase
        accept = rst_n & op_valid & ~flush & ~stall;
    end

    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (div_commit) begin
            {hi_nxt, lo_nxt} = div_result;
        end else if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = product;
                OP_MTHI:           hi_nxt = rs_data;
                OP_MTLO:           lo_nxt = rs_data;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hi_q  <= HILO_INIT;
            lo_q  <= HILO_INIT;
        end else begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
            case (state)
                IDLE:    if (div_op != DIV_IDLE) state <= WAIT;
                WAIT:    if (flush) state <= DRAIN;
                         else if (div_done) state <= IDLE;
                // A flushed divide still owns the divider until it reports done.
                DRAIN:   if (div_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi = hi_nxt;
    assign lo = lo_nxt;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed cases, then randomized ops against a flag-based reference model.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           op_valid;
    hilo_op_t       op;
    logic [W-1:0]   rs, rt;
    logic           flush;
    logic           stall;
    logic [W-1:0]   hi, lo;
    logic [1:0]     div_op;
    logic [W-1:0]   dd, dv;
    logic [2*W-1:0] div_result;
    logic           div_done;

    int n_chk  = 0;
    int n_pass = 0;

    hilo_ctrl #(.WIDTH(W), .HILO_INIT('0)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .rs_data(rs), .rt_data(rt), .flush(flush), .stall(stall),
        .hi(hi), .lo(lo), .div_op(div_op), .div_dividend(dd),
        .div_divisor(dv), .div_result(div_result), .div_done(div_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] divide(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int signed   qs, rsig;
        int unsigned qu, ru;
        if (b == 0) return 64'd0;
        if (sgn) begin
            qs = $signed(a) / $signed(b);
            rsig = $signed(a) % $signed(b);
            return {rsig, qs};
        end
        qu = a / b;
        ru = a % b;
        return {ru, qu};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Divider: done drops the cycle after issue and stays low for 34 cycles; not reset by rst_n.
    int unsigned div_cnt = 0;
    logic [63:0] div_res_q = '0;
    assign div_done   = (div_cnt == 0);
    assign div_result = div_res_q;
    always @(posedge clk) begin
        if (div_cnt != 0) div_cnt <= div_cnt - 1;
        else if (div_op != 2'b00) begin
            div_cnt   <= 34;
            div_res_q <= divide(div_op == DIV_SIGNED, dd, dv);
        end
    end

    // Reference model: architectural HI/LO plus "divide pending" and "divider draining" flags.
    logic [31:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
    bit          m_pend = 0, m_drain = 0, m_sgn = 0;
    logic [31:0] n_hi = '0, n_lo = '0, n_a = '0, n_b = '0;
    bit          n_pend = 0, n_drain = 0, n_sgn = 0;

    always @(negedge clk) begin
        bit          isdiv, e_stall;
        logic [1:0]  e_dop;
        longint      ps;
        longint unsigned pu;
        isdiv = rst_n && op_valid && !flush && (op == OP_DIV || op == OP_DIVU) && rt != 0;
        e_stall = 0; e_dop = 2'b00;
        n_hi = m_hi; n_lo = m_lo; n_pend = m_pend; n_drain = m_drain;
        n_sgn = m_sgn; n_a = m_a; n_b = m_b;
        if (rst_n) begin
            if (m_pend) begin
                if (flush) begin n_pend = 0; n_drain = 1; end
                else if (div_done) begin {n_hi, n_lo} = divide(m_sgn, m_a, m_b); n_pend = 0; end
                else e_stall = 1;
            end else begin
                e_stall = isdiv;
                if (m_drain && div_done) n_drain = 0;
                if (isdiv && !m_drain && div_done) begin
                    e_dop = (op == OP_DIV) ? 2'b10 : 2'b01;
                    n_pend = 1; n_sgn = (op == OP_DIV); n_a = rs; n_b = rt;
                end
                if (op_valid && !flush && !e_stall) begin
                    ps = longint'($signed(rs)) * longint'($signed(rt));
                    pu = longint'({32'd0, rs}) * longint'({32'd0, rt});
                    case (op)
                        OP_MULT:  {n_hi, n_lo} = ps;
                        OP_MULTU: {n_hi, n_lo} = pu;
                        OP_MTHI:  n_hi = rs;
                        OP_MTLO:  n_lo = rs;
                        default:  ;
                    endcase
                end
            end
        end
        chk("stall", {63'd0, stall}, {63'd0, e_stall});
        chk("div_op", {62'd0, div_op}, {62'd0, e_dop});
        chk("div_operands", {dd, dv}, {rs, rt});
`ifdef HILO_BYPASS_EN
        chk("hi", {32'd0, hi}, {32'd0, n_hi});
        chk("lo", {32'd0, lo}, {32'd0, n_lo});
`else
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
`endif
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_pend <= 0; m_drain <= 0;
        end else begin
            m_hi <= n_hi; m_lo <= n_lo; m_pend <= n_pend; m_drain <= n_drain;
            m_sgn <= n_sgn; m_a <= n_a; m_b <= n_b;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_in;
        op_valid = 0; op = OP_NONE; flush = 0; rs = '0; rt = '0;
    endtask

    task automatic set_op(input hilo_op_t o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1; op = o; rs = a; rt = b; flush = 0;
    endtask

    // Hold the current op until stall drops; returns the number of stalled cycles.
    task automatic run_div(output int cycles);
        bit done;
        cycles = 0; done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall) begin done = 1; break; end
            cycles++;
        end
        chk("div_timeout", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        idle_in();
    endtask

    initial begin
        int c;
        bit hold;
        rst_n = 0;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_div_op", {62'd0, div_op}, 64'd0);
        rst_n = 1;
        tick();

        set_op(OP_DIVU, 32'd100, 32'd7);
        run_div(c);
        chk("t1_stall_cycles", c, 64'd35);
        chk("t1_hi", {32'd0, hi}, 64'd2);
        chk("t1_lo", {32'd0, lo}, 64'd14);
        chk("t1_model_lo", {32'd0, m_lo}, 64'd14);

        set_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_div(c);
        chk("t2_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("t2_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("t2_model_hi", {32'd0, m_hi}, 64'hFFFF_FFFF);

        set_op(OP_MTHI, 32'h11, 32'd0); tick();
        set_op(OP_MTLO, 32'h22, 32'd0); tick();
        set_op(OP_DIV, 32'd5, 32'd0);
        @(negedge clk);
        chk("t3_stall", {63'd0, stall}, 64'd0);
        tick(); idle_in();
        chk("t3_hi", {32'd0, hi}, 64'h11);
        chk("t3_lo", {32'd0, lo}, 64'h22);

        set_op(OP_DIV, 32'd1000, 32'd3);
        repeat (10) tick();
        flush = 1;
        @(negedge clk);
        chk("t4_flush_stall", {63'd0, stall}, 64'd0);
        tick(); idle_in();
        chk("t4_hi_kept", {32'd0, hi}, 64'h11);
        chk("t4_lo_kept", {32'd0, lo}, 64'h22);
        tick();
        set_op(OP_DIVU, 32'd100, 32'd7);
        run_div(c);
        chk("t4_stall_cycles", c, 64'd59);
        chk("t4_hi", {32'd0, hi}, 64'd2);
        chk("t4_lo", {32'd0, lo}, 64'd14);

        set_op(OP_MULT, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        chk("t5_mult_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("t5_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        set_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        @(negedge clk);
        chk("t5_multu_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("t5_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        chk("t5_model", {m_hi, m_lo}, 64'h0000_0001_FFFF_FFFE);

        set_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        @(negedge clk);
`ifdef HILO_BYPASS_EN
        chk("t6_mthi_same", {32'd0, hi}, 64'hA5A5_A5A5);
`else
        chk("t6_mthi_same", {32'd0, hi}, 64'd1);
`endif
        tick(); idle_in();
        chk("t6_mthi_next", {32'd0, hi}, 64'hA5A5_A5A5);

        set_op(OP_DIV, 32'd500, 32'd9);
        repeat (6) tick();
        #2 rst_n = 0;
        #1;
        chk("t6_rst_hi", {32'd0, hi}, 64'd0);
        chk("t6_rst_lo", {32'd0, lo}, 64'd0);
        chk("t6_rst_stall", {63'd0, stall}, 64'd0);
        tick(); idle_in();
        rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            hold = stall;
            @(posedge clk); #1;
            if (!hold) begin
                op_valid = ($urandom_range(0, 7) != 0);
                op = hilo_op_t'($urandom_range(0, 6));
                rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom;
                case ($urandom_range(0, 7))
                    0:       rt = '0;
                    1, 2:    rt = $urandom_range(1, 15);
                    default: rt = $urandom;
                endcase
            end
            flush = ($urandom_range(0, 15) == 0);
        end
        idle_in();
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
